alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Front-end controller for the structural ALU. Accepts one op per valid/ready handshake, decodes
//  alu_fun[3:2] to one unit enable, drives operands, captures the registered unit result, and returns
//  it through a valid/ready result port. Builds multi-bit shifts by re-issuing the 1-bit shift unit.
// PARAMETERS
//  DATA_WIDTH  16  operand/result width; matches the ALU units
//  CNT_WIDTH   4   shift-amount width; max shift = 2**CNT_WIDTH-1
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           asynchronous, active-low reset
//  req_valid    in   1           request present
//  req_ready    out  1           sequencer can accept (IDLE only)
//  req_fun      in   4           [3:2] unit: 00 arith, 01 logic, 10 cmp, 11 shift; [1:0] unit sub-op
//  req_a/req_b  in   DATA_WIDTH  operands
//  req_shamt    in   CNT_WIDTH   shift repeat count; ignored unless req_fun[3:2]==11
//  unit_a/b     out  DATA_WIDTH  operands driven to all units
//  unit_fun     out  2           sub-op to units
//  arith_enable/logic_enable/cmp_enable/shift_enable  out 1  one-hot unit enables, at most one high
//  unit_out     in   DATA_WIDTH  OR of all unit outputs; disabled units return 0
//  unit_flag    in   1           OR of all unit flags
//  res_valid    out  1           result available
//  res_ready    in   1           consumer accepts result
//  res_data     out  DATA_WIDTH  result, stable while res_valid && !res_ready
//  res_err      out  1           unit flag missing (see CONFIGURATION); qualified by res_valid
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, working regs 0. Reset mid-op aborts it; nothing is replayed.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//   IDLE : req_ready=1. On req_valid, latch fun/a/b/shamt into wa/wb/cnt.
//          If shift with shamt==0: res_data = wa (fun[1]=0) or wb (fun[1]=1); go to DONE.
//          Otherwise go to ISSUE.
//   ISSUE: exactly one unit enable high for one cycle; unit_a=wa, unit_b=wb, unit_fun=fun[1:0].
//   WAIT : enables 0; unit registered output now valid; capture unit_out into wres.
//          Shift: cnt<=cnt-1, write wres into wa (fun[1]=0) or wb (fun[1]=1).
//          If remaining cnt!=0, go to ISSUE; else go to DONE.
//          Non-shift: go to DONE.
//   DONE : res_valid=1, res_data=wres. Hold until res_ready, then go to IDLE (req_ready rises next cycle).
//  Latency from accept edge to res_valid: 3 cycles non-shift; 2*shamt+1 shift; 1 for shamt==0.
//  Throughput: one op in flight; no new accept while res_valid pending.
//  Shift: logical, zero-fill, bits shifted out lost; widths are DATA_WIDTH throughout, no carry kept.
//  unit_a/b/fun hold their last values outside ISSUE; only the enables gate activity.
// CONFIGURATION
//  ALU_SEQ_FLAG_CHECK_EN defined: in each WAIT, unit_flag==0 sets a sticky op error and forces DONE
//   immediately (shift loop abandoned); res_err=1 with res_valid; clears on leaving DONE.
//  Undefined: unit_flag ignored, res_err tied 0.
// STRUCTURE
//  Package alu_seq_pkg: FSM state enum (IDLE/ISSUE/WAIT/DONE, 2 bits), unit-select constants
//  UNIT_ARITH/LOGIC/CMP/SHIFT (2'b00..2'b11).
//  Sub-module alu_seq_decode: combinational fun[3:2] + issue strobe -> one-hot enables.
//  FSM, counters and registers stay in the top.
// TESTING
//  1 Arith: fun=0000, a=5, b=3, unit_out=8 -> arith_enable pulses 1 cycle; res_valid 3 cycles
//    after accept; res_data=8.
//  2 Shift: fun=1101, a=16'h0001, shamt=4 -> 4 shift_enable pulses; res_data=16'h0010;
//    latency 9; b untouched.
//  3 Shift: shamt=0, fun=1110, b=16'hABCD -> no enable; res_valid 1 cycle later;
//    res_data=16'hABCD.
//  4 Backpressure: res_ready=0 for 5 cycles -> res_valid/res_data stable; req_ready=0;
//    second req_valid not accepted until after the handshake.
//  5 Reset: rst low during 3rd ISSUE of shamt=6 -> all outputs 0 at once; post-reset req_ready=1;
//    a new op completes correctly.
//  6 ALU_SEQ_FLAG_CHECK_EN: unit_flag forced 0 on an arith op -> res_valid with res_err=1;
//    next op gives res_err=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state type and unit-select codes for the ALU op sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: unit select + issue strobe -> one-hot unit enables
//   sel   in  unit select (fun[3:2])
//   issue in  high for the single issue cycle
//   *_enable out one-hot enables, all low unless issue
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       issue,
  output logic       arith_enable,
  output logic       logic_enable,
  output logic       cmp_enable,
  output logic       shift_enable
);
  assign arith_enable = issue && sel == UNIT_ARITH;
  assign logic_enable = issue && sel == UNIT_LOGIC;
  assign cmp_enable   = issue && sel == UNIT_CMP;
  assign shift_enable = issue && sel == UNIT_SHIFT;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front-end that issues ops to the ALU units and returns results
//   clk, rst (async active-low)
//   req_valid/req_ready/req_fun/req_a/req_b/req_shamt : request port
//   unit_a/unit_b/unit_fun, *_enable                  : drive to ALU units
//   unit_out/unit_flag                                : registered unit result, OR of units
//   res_valid/res_ready/res_data/res_err              : result port
//   ALU_SEQ_FLAG_CHECK_EN: when defined, a missing unit_flag in WAIT aborts to DONE with res_err
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_fun,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [CNT_WIDTH-1:0]  req_shamt,
  output logic [DATA_WIDTH-1:0] unit_a,
  output logic [DATA_WIDTH-1:0] unit_b,
  output logic [1:0]            unit_fun,
  output logic                  arith_enable,
  output logic                  logic_enable,
  output logic                  cmp_enable,
  output logic                  shift_enable,
  input  logic [DATA_WIDTH-1:0] unit_out,
  input  logic                  unit_flag,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err
);
  state_t state, next;
  logic [3:0] fun;
  logic [DATA_WIDTH-1:0] wa, wb, wres, na, nb;
  logic [CNT_WIDTH-1:0] cnt;
  logic issue, accept, shift_op, flag_fail;
  assign accept   = state == IDLE && req_valid;
  assign shift_op = fun[3:2] == UNIT_SHIFT;
  assign res_data = wres;
`ifdef ALU_SEQ_FLAG_CHECK_EN
  logic err;
  assign flag_fail = state == WAIT && !unit_flag;
  assign res_err   = err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (flag_fail) err <= 1'b1;
    else if (state == DONE && res_ready) err <= 1'b0;
`else
  logic unused_flag;
  assign unused_flag = unit_flag;
  assign flag_fail   = 1'b0;
  assign res_err     = 1'b0;
`endif
  // na/nb are the next working operands: request operands on accept, shift result fed back in WAIT
  always_comb begin
    next      = state;
    issue     = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    na        = wa;
    nb        = wb;
    case (state)
      IDLE: begin
        req_ready = rst;
        na = req_a;
        nb = req_b;
        if (req_valid) next = (req_fun[3:2] == UNIT_SHIFT && req_shamt == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        next  = WAIT;
      end
      WAIT: begin
        if (shift_op) begin
          na = fun[1] ? wa : unit_out;
          nb = fun[1] ? unit_out : wb;
        end
        next = (shift_op && cnt != CNT_WIDTH'(1) && !flag_fail) ? ISSUE : DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      fun      <= '0;
      wa       <= '0;
      wb       <= '0;
      wres     <= '0;
      cnt      <= '0;
      unit_a   <= '0;
      unit_b   <= '0;
      unit_fun <= '0;
    end else begin
      state <= next;
      if (accept) begin
        fun  <= req_fun;
        cnt  <= req_shamt;
        wres <= req_fun[1] ? req_b : req_a;
      end
      if (accept || state == WAIT) begin
        wa <= na;
        wb <= nb;
      end
      if (state == WAIT) begin
        wres <= unit_out;
        if (shift_op) cnt <= cnt - 1'b1;
      end
      if (next == ISSUE) begin
        unit_a   <= na;
        unit_b   <= nb;
        unit_fun <= accept ? req_fun[1:0] : fun[1:0];
      end
    end
  alu_seq_decode u_decode (
    .sel          (fun[3:2]),
    .issue        (issue),
    .arith_enable (arith_enable),
    .logic_enable (logic_enable),
    .cmp_enable   (cmp_enable),
    .shift_enable (shift_enable)
  );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench with a behavioural ALU unit model and result reference
module tb_alu_op_sequencer;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, res_ready = 1'b0, flag_zero = 1'b0;
  logic req_ready, res_valid, res_err;
  logic [3:0] req_fun = '0, req_shamt = '0;
  logic [15:0] req_a = '0, req_b = '0, unit_a, unit_b, res_data;
  logic [15:0] unit_out = '0;
  logic [1:0] unit_fun;
  logic arith_enable, logic_enable, cmp_enable, shift_enable, unit_flag;
  int n_chk = 0, n_fail = 0, pulses = 0, multi = 0;
  always #5 clk = ~clk;
  assign unit_flag = ~flag_zero;
  alu_op_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_fun(req_fun),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .unit_a(unit_a), .unit_b(unit_b),
    .unit_fun(unit_fun), .arith_enable(arith_enable), .logic_enable(logic_enable),
    .cmp_enable(cmp_enable), .shift_enable(shift_enable), .unit_out(unit_out),
    .unit_flag(unit_flag), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err)
  );
  function automatic logic [15:0] unit_fn(input logic [1:0] u, input logic [1:0] f,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [15:0] op;
    op = f[1] ? b : a;
    case (u)
      2'd0: return f[0] ? a - b : a + b;
      2'd1: return f == 2'd0 ? a & b : f == 2'd1 ? a | b : f == 2'd2 ? a ^ b : ~a;
      2'd2: return {15'd0, f == 2'd0 ? a == b : f == 2'd1 ? a < b : f == 2'd2 ? a > b : a != b};
      default: return f[0] ? op << 1 : op >> 1;
    endcase
  endfunction
  function automatic logic [15:0] ref_res(input logic [3:0] f, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] s);
    logic [15:0] op;
    op = f[1] ? b : a;
    if (f[3:2] == 2'b11) return f[0] ? op << s : op >> s;
    return unit_fn(f[3:2], f[1:0], a, b);
  endfunction
  always @(posedge clk) begin
    if (arith_enable | logic_enable | cmp_enable | shift_enable) begin
      pulses <= pulses + 1;
      unit_out <= unit_fn(shift_enable ? 2'd3 : cmp_enable ? 2'd2 : logic_enable ? 2'd1 : 2'd0,
                          unit_fun, unit_a, unit_b);
    end
    if (32'(arith_enable) + 32'(logic_enable) + 32'(cmp_enable) + 32'(shift_enable) > 1)
      multi <= multi + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input int stall, input bit fz,
                        input logic [15:0] ed, input int el, input bit ee, input int ep);
    int lat, p0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_fun = f; req_a = a; req_b = b; req_shamt = s;
    res_ready = 1'b0; flag_zero = fz; p0 = pulses;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_a = ~a; req_b = ~b;
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, el);
    chk("res_data", res_data, ed);
    chk("res_err", res_err, ee);
    chk("enable_pulses", pulses - p0, ep);
    if (f[3:2] == 2'b11 && !f[1] && s != 0) chk("b_untouched", unit_b, b);
    flag_zero = 1'b0;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_fun = 4'h0;
      @(negedge clk);
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, ed);
      chk("stall_no_accept", req_ready, 0);
    end
    req_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("onehot", multi, 0);
  endtask
  typedef struct {
    logic [3:0] fun; logic [15:0] a; logic [15:0] b; logic [3:0] shamt;
    int stall; logic [15:0] exp_data; int exp_lat; int exp_pulses;
  } vec_t;
  vec_t vecs[8];
  initial begin
    int k, p0;
    logic [3:0] f, s;
    logic [15:0] a, b;
    vecs[0] = '{4'b0000, 16'd5,     16'd3,     4'd0,  0, 16'd8,     3,  1};
    vecs[1] = '{4'b1101, 16'h0001,  16'h1234,  4'd4,  0, 16'h0010,  9,  4};
    vecs[2] = '{4'b1110, 16'h1111,  16'hABCD,  4'd0,  0, 16'hABCD,  1,  0};
    vecs[3] = '{4'b0001, 16'd3,     16'd5,     4'd0,  5, 16'hFFFE,  3,  1};
    vecs[4] = '{4'b0101, 16'hF0F0,  16'h0F0F,  4'd0,  1, 16'hFFFF,  3,  1};
    vecs[5] = '{4'b1000, 16'd7,     16'd7,     4'd9,  0, 16'h0001,  3,  1};
    vecs[6] = '{4'b1100, 16'h8000,  16'h5555,  4'd15, 2, 16'h0001,  31, 15};
    vecs[7] = '{4'b1111, 16'h5555,  16'h0001,  4'd15, 0, 16'h8000,  31, 15};
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_enables", {arith_enable, logic_enable, cmp_enable, shift_enable}, 0);
    chk("rst_unit_a", unit_a, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].shamt, vecs[i].stall, 1'b0,
             vecs[i].exp_data, vecs[i].exp_lat, 1'b0, vecs[i].exp_pulses);
    @(negedge clk);
    req_valid = 1'b1; req_fun = 4'b1101; req_a = 16'd3; req_b = 16'd9; req_shamt = 4'd6;
    p0 = pulses;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!(shift_enable && pulses - p0 == 2) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_third_issue", k < 100, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_enables", {arith_enable, logic_enable, cmp_enable, shift_enable}, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_unit", {unit_a, unit_b, 14'd0, unit_fun}, 0);
    chk("mid_rst_err", res_err, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(4'b0000, 16'd100, 16'd23, 4'd0, 0, 1'b0, 16'd123, 3, 1'b0, 1);
`ifdef ALU_SEQ_FLAG_CHECK_EN
    run_op(4'b0000, 16'd5, 16'd3, 4'd0, 1, 1'b1, 16'd8, 3, 1'b1, 1);
    run_op(4'b1101, 16'h0001, 16'd0, 4'd5, 0, 1'b1, 16'h0002, 3, 1'b1, 1);
    run_op(4'b0000, 16'd5, 16'd3, 4'd0, 0, 1'b0, 16'd8, 3, 1'b0, 1);
`else
    run_op(4'b0000, 16'd5, 16'd3, 4'd0, 1, 1'b1, 16'd8, 3, 1'b0, 1);
`endif
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
      s = 4'($urandom_range(0, 15));
      run_op(f, a, b, s, int'($urandom_range(0, 2)), 1'b0, ref_res(f, a, b, s),
             f[3:2] == 2'b11 ? (s == 0 ? 1 : 2 * int'(s) + 1) : 3, 1'b0,
             f[3:2] == 2'b11 ? int'(s) : 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
